imm_gen_pipe: RTL and testbench



---
 rtl/imm_gen_pipe.sv | 118 +++++++++++
 tb/tb_imm_gen_pipe.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/imm_gen_pipe.sv
// RV32/RV64 immediate generator with a valid/ready output stage backed by a skid register.
// in_ready is a decode of registered state only, so there is no combinational ready path.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int SRC_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [SRC_W-1:0] ImmSrc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  ImmOp,
    output logic             out_illegal
);

    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end

    localparam logic [SRC_W-1:0] SRC_I = SRC_W'(0);
    localparam logic [SRC_W-1:0] SRC_S = SRC_W'(1);
    localparam logic [SRC_W-1:0] SRC_B = SRC_W'(2);
    localparam logic [SRC_W-1:0] SRC_U = SRC_W'(3);
    localparam logic [SRC_W-1:0] SRC_J = SRC_W'(4);
    localparam logic [SRC_W-1:0] SRC_Z = SRC_W'(5);

    typedef enum logic [1:0] {
        EMPTY,
        ONE,
        FULL
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic            illegal;
    } entry_t;

    state_t      state, state_nxt;
    entry_t      dec_entry, out_reg, skid_reg;
    logic [31:0] imm32;
    logic        accept, drain;

    // Opcode bits never contribute to any immediate.
    logic unused_opcode;
    assign unused_opcode = ^instr[6:0];

    // Every format is built as a 32-bit value and then sign-extended; Z has bit 31 clear.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        imm32             = '0;
        dec_entry.illegal = 1'b0;
        case (ImmSrc)
            SRC_I:   imm32 = {{20{instr[31]}}, instr[31:20]};
            SRC_S:   imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            SRC_B:   imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            SRC_U:   imm32 = {instr[31:12], 12'b0};
            SRC_J:   imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            SRC_Z:   imm32 = {27'b0, instr[19:15]};
            default: dec_entry.illegal = 1'b1;
        endcase
        dec_entry.imm = XLEN'($signed(imm32));
    end

    assign accept = in_valid && in_ready;
    assign drain  = out_valid && out_ready;

    // NOTE: sequential state uses non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= EMPTY;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:   if (accept) state_nxt = ONE;
            ONE: begin
                if (accept && !drain)      state_nxt = FULL;
                else if (!accept && drain) state_nxt = EMPTY;
            end
            FULL:    if (drain) state_nxt = ONE;
            default: state_nxt = EMPTY;
        endcase
    end

    always_comb begin
        out_valid = (state != EMPTY);
        in_ready  = (state != FULL);
    end

    // NOTE: data registers are reset because ImmOp/out_illegal must read zero straight out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_reg  <= '0;
            skid_reg <= '0;
        end else begin
            case (state)
                EMPTY: if (accept) out_reg <= dec_entry;
                ONE: begin
                    if (accept && drain) out_reg  <= dec_entry;
                    else if (accept)     skid_reg <= dec_entry;
                end
                FULL: if (drain) begin
                    out_reg  <= skid_reg;
                    skid_reg <= '0;
                end
                default: ;
            endcase
        end
    end

    assign ImmOp       = out_reg.imm;
    assign out_illegal = out_reg.illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share one stimulus stream.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] instr;
    logic [2:0]  ImmSrc;
    logic        out_ready;

    logic        in_ready, out_valid, out_illegal;
    logic [31:0] ImmOp;
    logic        in_ready64, out_valid64, out_illegal64;
    logic [63:0] ImmOp64;

    int checks   = 0;
    int failures = 0;

    imm_gen_pipe #(.XLEN(32), .SRC_W(3)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .ImmSrc(ImmSrc), .out_valid(out_valid), .out_ready(out_ready), .ImmOp(ImmOp),
        .out_illegal(out_illegal)
    );

    imm_gen_pipe #(.XLEN(64), .SRC_W(3)) dut64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready64), .instr(instr),
        .ImmSrc(ImmSrc), .out_valid(out_valid64), .out_ready(out_ready), .ImmOp(ImmOp64),
        .out_illegal(out_illegal64)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] src, input logic [31:0] ins);
        in_valid = v;
        ImmSrc   = src;
        instr    = ins;
    endtask

    task automatic test_reset();
        rst = 1'b1; drive(1'b0, 3'd0, 32'h0); out_ready = 1'b0;
        #12;
        checks++; if (out_valid !== 1'b0)   begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        checks++; if (in_ready !== 1'b1)    begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        checks++; if (ImmOp !== 32'h0)      begin failures++; $display("FAIL reset_immop got=%h want=0", ImmOp); end
        checks++; if (out_illegal !== 1'b0) begin failures++; $display("FAIL reset_illegal got=%b want=0", out_illegal); end
        @(negedge clk); rst = 1'b0;
        step();
    endtask

    task automatic test_itype();
        drive(1'b1, 3'b000, 32'hFFF00093); out_ready = 1'b1;
        step();
        drive(1'b0, 3'b000, 32'h0);
        checks++; if (out_valid !== 1'b1)       begin failures++; $display("FAIL itype_valid got=%b want=1", out_valid); end
        checks++; if (ImmOp !== 32'hFFFFFFFF)   begin failures++; $display("FAIL itype_imm got=%h want=ffffffff", ImmOp); end
        checks++; if (out_illegal !== 1'b0)     begin failures++; $display("FAIL itype_illegal got=%b want=0", out_illegal); end
        step();
        checks++; if (out_valid !== 1'b0)       begin failures++; $display("FAIL itype_drained got=%b want=0", out_valid); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        drive(1'b1, 3'b010, 32'hFE000EE3); step();
        drive(1'b1, 3'b001, 32'h00000423);
        checks++; if (out_valid !== 1'b1 || ImmOp !== 32'hFFFFFFFC) begin failures++; $display("FAIL b2b_B got=%b/%h want=1/fffffffc", out_valid, ImmOp); end
        step();
        drive(1'b1, 3'b011, 32'h12345037);
        checks++; if (out_valid !== 1'b1 || ImmOp !== 32'h00000008) begin failures++; $display("FAIL b2b_S got=%b/%h want=1/00000008", out_valid, ImmOp); end
        step();
        drive(1'b0, 3'b000, 32'h0);
        checks++; if (out_valid !== 1'b1 || ImmOp !== 32'h12345000) begin failures++; $display("FAIL b2b_U got=%b/%h want=1/12345000", out_valid, ImmOp); end
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_empty got=%b want=0", out_valid); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(1'b1, 3'b000, 32'h00100093); step();
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b1) begin failures++; $display("FAIL bp_one got=rdy%b/v%b want=1/1", in_ready, out_valid); end
        drive(1'b1, 3'b011, 32'h80000037); step();
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_full_ready got=%b want=0", in_ready); end
        checks++; if (ImmOp !== 32'h00000001) begin failures++; $display("FAIL bp_hold_first got=%h want=00000001", ImmOp); end
        drive(1'b1, 3'b000, 32'h7FF00093); step();
        checks++; if (in_ready !== 1'b0 || ImmOp !== 32'h00000001) begin failures++; $display("FAIL bp_held_off got=rdy%b/%h want=0/00000001", in_ready, ImmOp); end
        out_ready = 1'b1; step();
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_back got=%b want=1", in_ready); end
        checks++; if (out_valid !== 1'b1 || ImmOp !== 32'h80000000) begin failures++; $display("FAIL bp_second got=%b/%h want=1/80000000", out_valid, ImmOp); end
        step();
        drive(1'b0, 3'b000, 32'h0);
        checks++; if (out_valid !== 1'b1 || ImmOp !== 32'h000007FF) begin failures++; $display("FAIL bp_third got=%b/%h want=1/000007ff", out_valid, ImmOp); end
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_empty got=%b want=0", out_valid); end
    endtask

    task automatic test_illegal();
        out_ready = 1'b1;
        drive(1'b1, 3'b000, 32'h00500093); step();
        drive(1'b1, 3'b111, 32'hFFFFFFFF);
        checks++; if (ImmOp !== 32'h5 || out_illegal !== 1'b0) begin failures++; $display("FAIL ill_pre got=%h/%b want=00000005/0", ImmOp, out_illegal); end
        step();
        drive(1'b1, 3'b110, 32'h12345678);
        checks++; if (out_valid !== 1'b1 || ImmOp !== 32'h0 || out_illegal !== 1'b1) begin failures++; $display("FAIL ill_111 got=%b/%h/%b want=1/00000000/1", out_valid, ImmOp, out_illegal); end
        step();
        drive(1'b1, 3'b100, 32'h008000EF);
        checks++; if (out_valid !== 1'b1 || ImmOp !== 32'h0 || out_illegal !== 1'b1) begin failures++; $display("FAIL ill_110 got=%b/%h/%b want=1/00000000/1", out_valid, ImmOp, out_illegal); end
        step();
        drive(1'b0, 3'b000, 32'h0);
        checks++; if (ImmOp !== 32'h8 || out_illegal !== 1'b0) begin failures++; $display("FAIL ill_post_J got=%h/%b want=00000008/0", ImmOp, out_illegal); end
        step();
    endtask

    task automatic test_xlen64();
        out_ready = 1'b1;
        drive(1'b1, 3'b000, 32'hFFF00093); step();
        drive(1'b1, 3'b101, 32'h000F8073);
        checks++; if (out_valid64 !== 1'b1 || ImmOp64 !== 64'hFFFFFFFFFFFFFFFF) begin failures++; $display("FAIL x64_I got=%b/%h want=1/ffffffffffffffff", out_valid64, ImmOp64); end
        step();
        drive(1'b1, 3'b011, 32'h80000037);
        checks++; if (ImmOp64 !== 64'h1F || out_illegal64 !== 1'b0) begin failures++; $display("FAIL x64_Z got=%h/%b want=000000000000001f/0", ImmOp64, out_illegal64); end
        checks++; if (ImmOp !== 32'h1F) begin failures++; $display("FAIL x32_Z got=%h want=0000001f", ImmOp); end
        step();
        drive(1'b0, 3'b000, 32'h0);
        checks++; if (ImmOp64 !== 64'hFFFFFFFF80000000) begin failures++; $display("FAIL x64_U got=%h want=ffffffff80000000", ImmOp64); end
        step();
    endtask

    task automatic test_reset_full();
        out_ready = 1'b0;
        drive(1'b1, 3'b000, 32'h00300093); step();
        drive(1'b1, 3'b000, 32'h00400093); step();
        drive(1'b0, 3'b000, 32'h0);
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL rf_full got=%b want=0", in_ready); end
        #2 rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++; $display("FAIL rf_async got=v%b/rdy%b want=0/1", out_valid, in_ready); end
        checks++; if (ImmOp !== 32'h0) begin failures++; $display("FAIL rf_imm got=%h want=0", ImmOp); end
        @(negedge clk); rst = 1'b0;
        out_ready = 1'b1;
        drive(1'b1, 3'b000, 32'h00100093); step();
        drive(1'b0, 3'b000, 32'h0);
        checks++; if (out_valid !== 1'b1 || ImmOp !== 32'h1) begin failures++; $display("FAIL rf_first got=%b/%h want=1/00000001", out_valid, ImmOp); end
        step();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rf_no_stale got=%b want=0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_itype();
        test_back_to_back();
        test_backpressure();
        test_illegal();
        test_xlen64();
        test_reset_full();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
